crossbar_pkt_checker: RTL

- Receive-side endpoint for crossbar/router load tests; one instance sits on each router output port and consumes packets produced by the test traffic generators.
- Validates each packet's header, length, payload pattern and per-source sequence number, and measures injection-to-ejection latency against a shared timestamp.
- Exposes saturating error counters and latency statistics so the bench (or an on-chip register file) reads results without a software scoreboard.

---
 rtl/crossbar_test_pkg.sv | 32 +++
 rtl/axis_ready_throttle.sv | 27 ++
 rtl/crossbar_pkt_checker.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/crossbar_test_pkg.sv
// Shared definitions for the crossbar load-test traffic generators and checkers:
// header field layout, payload line pattern, FSM state encodings, LFSR taps.
package crossbar_test_pkg;

    localparam int unsigned SRC_LSB = 56;
    localparam int unsigned SRC_W   = 8;
    localparam int unsigned DST_LSB = 48;
    localparam int unsigned DST_W   = 8;
    localparam int unsigned SEQ_LSB = 32;
    localparam int unsigned SEQ_W   = 16;
    localparam int unsigned TS_LSB  = 0;
    localparam int unsigned TS_W    = 32;

    localparam logic [1:0] ST_HEADER  = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    // x^8 + x^6 + x^5 + x^4 + 1, expressed as a mask over lfsr[7:0]
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] LFSR_SEED = 8'hB8;

    // Payload line k of a packet: header identity fields followed by the line index
    function automatic logic [63:0] payload_line(input logic [7:0] src, input logic [7:0] dst,
                                                 input logic [15:0] seq, input logic [31:0] k);
        return {src, dst, seq, k};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axis_ready_throttle.sv
// Pseudo-random sink back-pressure: an 8-bit LFSR compared against a threshold.
module axis_ready_throttle
    import crossbar_test_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] thresh,
    output logic       ready
);

    logic [7:0] lfsr;
    logic       feedback;

    assign feedback = ^(lfsr & LFSR_TAPS);

    // Advance the LFSR every cycle and register the ready decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr  <= LFSR_SEED;
            ready <= 1'b0;
        end else begin
            lfsr  <= {lfsr[6:0], feedback};
            ready <= (thresh == 8'hFF) || (lfsr < thresh);
        end
    end

endmodule

// File: rtl/crossbar_pkt_checker.sv
// Receive-side packet checker for crossbar load tests: validates header, length,
// payload pattern and per-source sequence, and gathers latency statistics.
module crossbar_pkt_checker
    import crossbar_test_pkg::*;
#(
    parameter int MY_PORT  = 0,
    parameter int NUM_SRCS = 4,
    parameter int DWIDTH   = 64,
    parameter int LPP      = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [31:0]       ts_in,
    input  logic [7:0]        throttle_thresh,
    input  logic              stats_clear,
    output logic [31:0]       pkt_count,
    output logic [15:0]       err_hdr,
    output logic [15:0]       err_len,
    output logic [15:0]       err_data,
    output logic [15:0]       err_seq,
    output logic [31:0]       lat_min,
    output logic [31:0]       lat_max,
    output logic [47:0]       lat_sum,
    output logic              busy
);

    localparam int          IW        = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
    localparam logic [15:0] LAST_LINE = 16'(LPP - 1);
    localparam logic [7:0]  MY_DST    = 8'(MY_PORT);
    localparam logic [8:0]  SRC_LIMIT = 9'(NUM_SRCS);

    logic [1:0]  state;
    logic [7:0]  cur_src;
    logic [7:0]  cur_dst;
    logic [15:0] cur_seq;
    logic [15:0] line_cnt;
    logic        bad_flag;
    logic [15:0] exp_seq [0:(2**IW)-1];

    logic [7:0]  f_src;
    logic [7:0]  f_dst;
    logic [15:0] f_seq;
    logic [31:0] f_ts;
    logic        beat;
    logic        hdr_bad;
    logic        line_mismatch;
    logic [31:0] latency;

    logic ev_pkt, ev_hdr, ev_len, ev_data, ev_seq, ev_lat, ev_exp;

    axis_ready_throttle u_throttle (
        .clk    (clk),
        .rst_n  (rst_n),
        .thresh (throttle_thresh),
        .ready  (s_axis_tready)
    );

    assign f_src         = s_axis_tdata[SRC_LSB +: SRC_W];
    assign f_dst         = s_axis_tdata[DST_LSB +: DST_W];
    assign f_seq         = s_axis_tdata[SEQ_LSB +: SEQ_W];
    assign f_ts          = s_axis_tdata[TS_LSB +: TS_W];
    assign beat          = s_axis_tvalid && s_axis_tready;
    assign hdr_bad       = (f_dst != MY_DST) || ({1'b0, f_src} >= SRC_LIMIT);
    assign latency       = ts_in - f_ts;
    assign line_mismatch = s_axis_tdata != payload_line(cur_src, cur_dst, cur_seq, {16'd0, line_cnt});
    assign busy          = state != ST_HEADER;

    // Decode which statistics events the current beat produces
    always_comb begin
        ev_pkt  = 1'b0;
        ev_hdr  = 1'b0;
        ev_len  = 1'b0;
        ev_data = 1'b0;
        ev_seq  = 1'b0;
        ev_lat  = 1'b0;
        ev_exp  = 1'b0;
        if (beat) begin
            case (state)
                ST_HEADER: begin
                    ev_lat = 1'b1;
                    if (hdr_bad) begin
                        ev_hdr = 1'b1;
                        ev_pkt = s_axis_tlast;
                    end else begin
                        ev_exp = 1'b1;
                        ev_seq = f_seq != exp_seq[f_src[IW-1:0]];
                        ev_len = s_axis_tlast;
                        ev_pkt = s_axis_tlast;
                    end
                end
                ST_PAYLOAD: begin
                    if (s_axis_tlast) begin
                        ev_pkt  = 1'b1;
                        ev_len  = line_cnt < LAST_LINE;
                        ev_data = bad_flag || line_mismatch;
                    end else begin
                        ev_len = line_cnt == LAST_LINE;
                    end
                end
                ST_DRAIN: ev_pkt = s_axis_tlast;
                default: ;
            endcase
        end
    end

    // Packet framing FSM; stats_clear deliberately leaves it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HEADER;
            cur_src  <= '0;
            cur_dst  <= '0;
            cur_seq  <= '0;
            line_cnt <= '0;
            bad_flag <= 1'b0;
        end else if (beat) begin
            case (state)
                ST_HEADER: begin
                    cur_src  <= f_src;
                    cur_dst  <= f_dst;
                    cur_seq  <= f_seq;
                    bad_flag <= 1'b0;
                    line_cnt <= 16'd1;
                    if (s_axis_tlast)
                        state <= ST_HEADER;
                    else if (hdr_bad)
                        state <= ST_DRAIN;
                    else
                        state <= ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (s_axis_tlast) begin
                        bad_flag <= 1'b0;
                        state    <= ST_HEADER;
                    end else if (line_cnt == LAST_LINE) begin
                        bad_flag <= 1'b0;
                        state    <= ST_DRAIN;
                    end else begin
                        bad_flag <= bad_flag || line_mismatch;
                        line_cnt <= line_cnt + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    if (s_axis_tlast)
                        state <= ST_HEADER;
                end
                default: state <= ST_HEADER;
            endcase
        end
    end

    // Counters, latency statistics and expected-sequence table; clear overrides any event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
            err_hdr   <= '0;
            err_len   <= '0;
            err_data  <= '0;
            err_seq   <= '0;
            lat_min   <= '1;
            lat_max   <= '0;
            lat_sum   <= '0;
            for (int unsigned i = 0; i < 2**IW; i++) exp_seq[i] <= '0;
        end else if (stats_clear) begin
            pkt_count <= '0;
            err_hdr   <= '0;
            err_len   <= '0;
            err_data  <= '0;
            err_seq   <= '0;
            lat_min   <= '1;
            lat_max   <= '0;
            lat_sum   <= '0;
            for (int unsigned i = 0; i < 2**IW; i++) exp_seq[i] <= '0;
        end else begin
            if (ev_pkt)  pkt_count <= pkt_count + 32'd1;
            if (ev_hdr)  err_hdr   <= sat_inc16(err_hdr);
            if (ev_len)  err_len   <= sat_inc16(err_len);
            if (ev_data) err_data  <= sat_inc16(err_data);
            if (ev_seq)  err_seq   <= sat_inc16(err_seq);
            if (ev_lat) begin
                if (latency < lat_min) lat_min <= latency;
                if (latency > lat_max) lat_max <= latency;
                lat_sum <= lat_sum + {16'd0, latency};
            end
            if (ev_exp) exp_seq[f_src[IW-1:0]] <= f_seq + 16'd1;
        end
    end

endmodule
